decode_stage_p: RTL and testbench

DECODE_STAGE_P -- requirements
Module: decode_stage_p

---
 rtl/decode_stage_p.sv | 152 +++++++++++++++
 tb/tb_decode_stage_p.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_p.sv
// Decode stage: register-file read, operand forwarding, load-use/RAW hazard
// detection, branch resolution and a single output register toward EX.
module decode_stage_p #(
  parameter int DW     = 16,
  parameter int FWD_EN = 1,
  parameter int BNZ_EN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  output logic [2:0]    rs1_addr,
  output logic [2:0]    rs2_addr,
  input  logic [DW-1:0] rs1_rdata,
  input  logic [DW-1:0] rs2_rdata,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_wb_en,
  input  logic [2:0]    mem_dest,
  input  logic [DW-1:0] mem_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_cmd,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [DW-1:0] store_data,
  output logic [2:0]    dest,
  output logic          mem_write_en,
  output logic          wb_mux,
  output logic          wb_en,
  output logic          branch_taken,
  output logic [5:0]    branch_offset
);

  function automatic logic [DW-1:0] sext6(input logic [5:0] imm);
    return {{(DW-6){imm[5]}}, imm};
  endfunction

  logic          r_out_valid;
  logic [2:0]    r_alu_cmd;
  logic [DW-1:0] r_op_a;
  logic [DW-1:0] r_op_b;
  logic [DW-1:0] r_store_data;
  logic [2:0]    r_dest;
  logic          r_mem_write_en;
  logic          r_wb_mux;
  logic          r_wb_en;

  logic [3:0]    w_opc;
  logic [3:0]    w_rcmd;
  logic [2:0]    w_rd;
  logic          w_is_r, w_is_addi, w_is_ld, w_is_st, w_is_bz, w_is_bnz;
  logic          w_use1, w_use2;
  logic          w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
  logic          w_raw1, w_raw2, w_ld_hit1, w_ld_hit2;
  logic          w_hazard, w_advance, w_load;
  logic [DW-1:0] w_a, w_b;

  assign w_opc     = in_instr[15:12];
  assign w_rcmd    = w_opc - 4'd1;
  assign w_rd      = in_instr[11:9];
  assign w_is_r    = (w_opc >= 4'd1) && (w_opc <= 4'd8);
  assign w_is_addi = (w_opc == 4'd9);
  assign w_is_ld   = (w_opc == 4'd10);
  assign w_is_st   = (w_opc == 4'd11);
  assign w_is_bz   = (w_opc == 4'd12);
  assign w_is_bnz  = (BNZ_EN != 0) && (w_opc == 4'd13);
  assign w_use1    = w_is_r | w_is_addi | w_is_ld | w_is_st | w_is_bz | w_is_bnz;
  assign w_use2    = w_is_r | w_is_st;

  // ST reads its data register through the rd field
  assign rs1_addr = in_instr[8:6];
  assign rs2_addr = w_is_st ? in_instr[11:9] : in_instr[5:3];

  assign w_ex_hit1  = r_out_valid && r_wb_en && !r_wb_mux && (r_dest == rs1_addr);
  assign w_ex_hit2  = r_out_valid && r_wb_en && !r_wb_mux && (r_dest == rs2_addr);
  assign w_mem_hit1 = mem_wb_en && (mem_dest == rs1_addr);
  assign w_mem_hit2 = mem_wb_en && (mem_dest == rs2_addr);
  assign w_ld_hit1  = r_out_valid && r_wb_mux && (r_dest == rs1_addr);
  assign w_ld_hit2  = r_out_valid && r_wb_mux && (r_dest == rs2_addr);
  assign w_raw1     = (r_out_valid && r_wb_en && (r_dest == rs1_addr)) || w_mem_hit1;
  assign w_raw2     = (r_out_valid && r_wb_en && (r_dest == rs2_addr)) || w_mem_hit2;

  always_comb begin
    w_a = rs1_rdata;
    w_b = rs2_rdata;
    if (FWD_EN != 0) begin
      if (w_ex_hit1)       w_a = ex_result;
      else if (w_mem_hit1) w_a = mem_result;
      if (w_ex_hit2)       w_b = ex_result;
      else if (w_mem_hit2) w_b = mem_result;
    end
  end

  assign w_hazard = (FWD_EN != 0) ? ((w_use1 && w_ld_hit1) || (w_use2 && w_ld_hit2))
                                  : ((w_use1 && w_raw1) || (w_use2 && w_raw2));

  assign w_advance    = !r_out_valid || out_ready;
  assign in_ready     = in_valid && w_advance && !w_hazard && !rst;
  assign branch_taken = in_ready && ((w_is_bz && (w_a == '0)) || (w_is_bnz && (w_a != '0)));
  assign w_load       = in_ready && !branch_taken;
  assign branch_offset = in_instr[5:0];

  // ---- output register (decode -> execute boundary) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_alu_cmd      <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_store_data   <= '0;
      r_dest         <= '0;
      r_mem_write_en <= 1'b0;
      r_wb_mux       <= 1'b0;
      r_wb_en        <= 1'b0;
    end else if (w_advance) begin
      if (w_load) begin
        r_out_valid    <= 1'b1;
        r_alu_cmd      <= w_is_r ? w_rcmd[2:0] : 3'd0;
        r_op_a         <= w_a;
        r_op_b         <= w_is_r ? w_b :
                          (w_is_addi | w_is_ld | w_is_st) ? sext6(in_instr[5:0]) : '0;
        r_store_data   <= w_is_st ? w_b : '0;
        r_dest         <= (w_is_r | w_is_addi | w_is_ld | w_is_st) ? w_rd : 3'd0;
        r_mem_write_en <= w_is_st;
        r_wb_mux       <= w_is_ld;
        r_wb_en        <= w_is_r | w_is_addi | w_is_ld;
      end else begin
        r_out_valid    <= 1'b0;
        r_alu_cmd      <= '0;
        r_op_a         <= '0;
        r_op_b         <= '0;
        r_store_data   <= '0;
        r_dest         <= '0;
        r_mem_write_en <= 1'b0;
        r_wb_mux       <= 1'b0;
        r_wb_en        <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign alu_cmd      = r_alu_cmd;
  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign store_data   = r_store_data;
  assign dest         = r_dest;
  assign mem_write_en = r_mem_write_en;
  assign wb_mux       = r_wb_mux;
  assign wb_en        = r_wb_en;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: three instances (default, no forwarding,
// BNZ enabled) share one stimulus stream; each test checks the relevant one.
module tb_decode_stage_p;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic [15:0] rs1_rdata = '0, rs2_rdata = '0, ex_result = '0, mem_result = '0;
  logic        mem_wb_en = 1'b0;
  logic [2:0]  mem_dest = '0;
  logic        out_ready = 1'b1;

  logic        in_ready [3];
  logic [2:0]  rs1_addr [3];
  logic [2:0]  rs2_addr [3];
  logic        out_valid [3];
  logic [2:0]  alu_cmd [3];
  logic [15:0] op_a [3];
  logic [15:0] op_b [3];
  logic [15:0] store_data [3];
  logic [2:0]  dest [3];
  logic        mem_write_en [3];
  logic        wb_mux [3];
  logic        wb_en [3];
  logic        branch_taken [3];
  logic [5:0]  branch_offset [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_stage_p #(.DW(16), .FWD_EN(1), .BNZ_EN(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready[0]),
    .rs1_addr(rs1_addr[0]), .rs2_addr(rs2_addr[0]), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .ex_result(ex_result), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
    .out_valid(out_valid[0]), .out_ready(out_ready), .alu_cmd(alu_cmd[0]), .op_a(op_a[0]),
    .op_b(op_b[0]), .store_data(store_data[0]), .dest(dest[0]), .mem_write_en(mem_write_en[0]),
    .wb_mux(wb_mux[0]), .wb_en(wb_en[0]), .branch_taken(branch_taken[0]),
    .branch_offset(branch_offset[0]));

  decode_stage_p #(.DW(16), .FWD_EN(0), .BNZ_EN(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready[1]),
    .rs1_addr(rs1_addr[1]), .rs2_addr(rs2_addr[1]), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .ex_result(ex_result), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
    .out_valid(out_valid[1]), .out_ready(out_ready), .alu_cmd(alu_cmd[1]), .op_a(op_a[1]),
    .op_b(op_b[1]), .store_data(store_data[1]), .dest(dest[1]), .mem_write_en(mem_write_en[1]),
    .wb_mux(wb_mux[1]), .wb_en(wb_en[1]), .branch_taken(branch_taken[1]),
    .branch_offset(branch_offset[1]));

  decode_stage_p #(.DW(16), .FWD_EN(1), .BNZ_EN(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready[2]),
    .rs1_addr(rs1_addr[2]), .rs2_addr(rs2_addr[2]), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .ex_result(ex_result), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
    .out_valid(out_valid[2]), .out_ready(out_ready), .alu_cmd(alu_cmd[2]), .op_a(op_a[2]),
    .op_b(op_b[2]), .store_data(store_data[2]), .dest(dest[2]), .mem_write_en(mem_write_en[2]),
    .wb_mux(wb_mux[2]), .wb_en(wb_en[2]), .branch_taken(branch_taken[2]),
    .branch_offset(branch_offset[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int lo6);
    logic [3:0] o;
    logic [2:0] d;
    logic [2:0] s;
    logic [5:0] l;
    o = 4'(op); d = 3'(rd); s = 3'(rs1); l = 6'(lo6);
    return {o, d, s, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    mem_wb_en = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state with an instruction already offered
    in_valid = 1'b1;
    in_instr = enc(9, 1, 0, 6'h3D);
    #2;
    chk("rst_in_ready", in_ready[0], 0);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_op_b", op_b[0], 0);
    chk("rst_wb_en", wb_en[0], 0);
    tick();
    rst = 1'b0;

    // ADDI r1,r0,-3
    in_valid = 1'b1; in_instr = enc(9, 1, 0, 6'h3D); rs1_rdata = 16'd5;
    #1;
    chk("addi_in_ready", in_ready[0], 1);
    chk("addi_rs1_addr", rs1_addr[0], 0);
    tick();
    in_valid = 1'b0;
    chk("addi_out_valid", out_valid[0], 1);
    chk("addi_alu_cmd", alu_cmd[0], 0);
    chk("addi_op_a", op_a[0], 16'd5);
    chk("addi_op_b", op_b[0], 16'hFFFD);
    chk("addi_dest", dest[0], 1);
    chk("addi_wb_en", wb_en[0], 1);
    chk("addi_wb_mux", wb_mux[0], 0);

    // LD r2 then ADD r3,r2,r4: load-use bubble then MEM forward
    do_reset();
    in_valid = 1'b1; in_instr = enc(10, 2, 1, 4); rs1_rdata = 16'd100;
    tick();
    chk("ld_out_valid", out_valid[0], 1);
    chk("ld_wb_mux", wb_mux[0], 1);
    chk("ld_op_a", op_a[0], 16'd100);
    chk("ld_op_b", op_b[0], 16'd4);
    in_instr = enc(1, 3, 2, 6'(4 << 3));
    #1;
    chk("lu_in_ready", in_ready[0], 0);
    tick();
    chk("lu_bubble_valid", out_valid[0], 0);
    chk("lu_bubble_dest", dest[0], 0);
    mem_wb_en = 1'b1; mem_dest = 3'd2; mem_result = 16'h1234;
    rs1_rdata = 16'd9; rs2_rdata = 16'h0042;
    #1;
    chk("lu_retry_ready", in_ready[0], 1);
    tick();
    in_valid = 1'b0; mem_wb_en = 1'b0;
    chk("lu_add_valid", out_valid[0], 1);
    chk("lu_add_op_a", op_a[0], 16'h1234);
    chk("lu_add_op_b", op_b[0], 16'h0042);
    chk("lu_add_dest", dest[0], 3);

    // ADD r1 then SUB r5,r1,r1: EX forward (u0), RAW stall (u1)
    do_reset();
    in_valid = 1'b1; in_instr = enc(1, 1, 2, 6'(3 << 3)); rs1_rdata = 16'd10; rs2_rdata = 16'd20;
    tick();
    chk("fw_add_dest", dest[0], 1);
    chk("nf_add_valid", out_valid[1], 1);
    in_instr = enc(2, 5, 1, 6'(1 << 3)); ex_result = 16'd30;
    mem_wb_en = 1'b1; mem_dest = 3'd1; mem_result = 16'd777;
    #1;
    chk("fw_sub_ready", in_ready[0], 1);
    chk("nf_sub_stall_ex", in_ready[1], 0);
    tick();
    chk("fw_sub_alu_cmd", alu_cmd[0], 1);
    chk("fw_sub_op_a", op_a[0], 16'd30);
    chk("fw_sub_op_b", op_b[0], 16'd30);
    chk("fw_sub_dest", dest[0], 5);
    chk("nf_bubble", out_valid[1], 0);
    #1;
    chk("nf_sub_stall_mem", in_ready[1], 0);
    tick();
    mem_wb_en = 1'b0; rs1_rdata = 16'd31; rs2_rdata = 16'd32;
    #1;
    chk("nf_sub_ready", in_ready[1], 1);
    tick();
    in_valid = 1'b0;
    chk("nf_sub_valid", out_valid[1], 1);
    chk("nf_sub_op_a", op_a[1], 16'd31);
    chk("nf_sub_op_b", op_b[1], 16'd32);

    // BZ / BNZ
    do_reset();
    in_valid = 1'b1; in_instr = enc(12, 0, 3, 5); rs1_rdata = 16'd0;
    #1;
    chk("bz0_taken", branch_taken[0], 1);
    chk("bz0_ready", in_ready[0], 1);
    chk("bz0_offset", branch_offset[0], 5);
    tick();
    chk("bz0_no_issue", out_valid[0], 0);
    rs1_rdata = 16'd7;
    #1;
    chk("bz7_taken", branch_taken[0], 0);
    chk("bz7_ready", in_ready[0], 1);
    tick();
    chk("bz7_issue", out_valid[0], 1);
    in_instr = enc(13, 0, 3, 0);
    #1;
    chk("bnz_dis_taken", branch_taken[0], 0);
    chk("bnz_en_taken", branch_taken[2], 1);
    tick();
    in_valid = 1'b0;
    chk("bnz_en_no_issue", out_valid[2], 0);
    chk("bnz_dis_issue", out_valid[0], 1);

    // ST addressing
    do_reset();
    in_valid = 1'b1; in_instr = enc(11, 6, 2, 6'h3F); rs1_rdata = 16'd50; rs2_rdata = 16'hBEEF;
    #1;
    chk("st_rs2_addr", rs2_addr[0], 6);
    tick();
    in_valid = 1'b0;
    chk("st_mem_we", mem_write_en[0], 1);
    chk("st_data", store_data[0], 16'hBEEF);
    chk("st_op_b", op_b[0], 16'hFFFF);
    chk("st_wb_en", wb_en[0], 0);

    // backpressure hold, then reset mid-hold
    do_reset();
    in_valid = 1'b1; in_instr = enc(9, 1, 0, 2); rs1_rdata = 16'd5;
    tick();
    out_ready = 1'b0;
    in_instr = enc(1, 2, 3, 6'(4 << 3)); rs1_rdata = 16'd99; rs2_rdata = 16'd98;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", in_ready[0], 0);
      chk("hold_valid", out_valid[0], 1);
      chk("hold_op_a", op_a[0], 16'd5);
      chk("hold_op_b", op_b[0], 16'd2);
      tick();
    end
    in_instr = enc(2, 4, 1, 0);
    #1;
    chk("hold_hz_ready", in_ready[0], 0);
    tick();
    chk("hold_hz_valid", out_valid[0], 1);
    chk("hold_hz_dest", dest[0], 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid[0], 0);
    chk("midrst_op_a", op_a[0], 0);
    chk("midrst_ready", in_ready[0], 0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    in_instr = enc(9, 7, 0, 1); rs1_rdata = 16'd3;
    #1;
    chk("postrst_ready", in_ready[0], 1);
    tick();
    in_valid = 1'b0;
    chk("postrst_valid", out_valid[0], 1);
    chk("postrst_dest", dest[0], 7);
    chk("postrst_op_b", op_b[0], 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
